// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the seven-segment bus reader.
//   - seg_pattern_t : 7-bit active-low segment pattern, [6:0] = g..a (0 = lit)
//   - char_code_t   : 2-bit recovered character code
//   - SEG_*         : the four legal display patterns
//   - CODE_*        : the matching character codes
// ----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg_pattern_t;
    typedef logic [1:0] char_code_t;

    localparam seg_pattern_t SEG_D     = 7'b0100001;
    localparam seg_pattern_t SEG_E     = 7'b0000110;
    localparam seg_pattern_t SEG_ONE   = 7'b1111001;
    localparam seg_pattern_t SEG_BLANK = 7'b1111111;

    localparam char_code_t CODE_D     = 2'b00;
    localparam char_code_t CODE_E     = 2'b01;
    localparam char_code_t CODE_ONE   = 2'b10;
    localparam char_code_t CODE_BLANK = 2'b11;

endpackage : seg7_pkg

// File: rtl/seg7_classify.sv
// ----------------------------------------------------------------------------
// seg7_classify
//   Combinational pattern classifier: maps an active-low segment pattern to
//   its character code and flags whether it is one of the legal characters.
//   Ports:
//     pattern_i  in   7  active-low segment pattern
//     legal_o    out  1  pattern is 'd', 'E', '1' or blank
//     code_o     out  2  character code (CODE_D when illegal; ignore then)
// ----------------------------------------------------------------------------
module seg7_classify
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       legal_o,
    output logic [1:0] code_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        legal_o = 1'b1;
        code_o  = CODE_D;
        unique case (pattern_i)
            SEG_D:     code_o = CODE_D;
            SEG_E:     code_o = CODE_E;
            SEG_ONE:   code_o = CODE_ONE;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule : seg7_classify

// File: rtl/seven_segment_reader.sv
// ----------------------------------------------------------------------------
// seven_segment_reader
//   Watches an active-low seven-segment bus, waits until a pattern has been
//   sampled STABLE_CYCLES times in a row, then classifies it. Legal characters
//   are handed out through a one-entry valid/ready register; illegal ones
//   raise a one-cycle bad_pulse and bump a saturating error counter.
//   Ports:
//     clk        in   1      rising-edge clock
//     resetn     in   1      synchronous active-low reset
//     sample_en  in   1      seg_in is sampled only when 1
//     seg_in     in   7      active-low segments [6:0] = g..a
//     out_valid  out  1      out_code holds an undelivered code
//     out_ready  in   1      consumer accepts when out_valid & out_ready
//     out_code   out  2      recovered character code
//     bad_pulse  out  1      one-cycle pulse on an illegal stable pattern
//     overflow   out  1      sticky: a legal code was dropped (register full)
//     err_count  out  ERR_W  illegal stable patterns seen, saturating
// ----------------------------------------------------------------------------
module seven_segment_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sample_en,
    input  logic [6:0]       seg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic             bad_pulse,
    output logic             overflow,
    output logic [ERR_W-1:0] err_count
);

    // Counter wide enough to hold STABLE_CYCLES itself (it saturates there).
    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seg_pattern_t     cand_q,      cand_d;
    logic             cand_vld_q,  cand_vld_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    char_code_t       out_code_q,  out_code_d;
    logic             bad_q,       bad_d;
    logic             ovf_q,       ovf_d;
    logic [ERR_W-1:0] err_q,       err_d;

    logic       commit;
    logic       pat_legal;
    char_code_t pat_code;
    logic       consume;

    // On a commit edge the candidate equals seg_in, so classify seg_in directly
    // and avoid waiting a cycle for the candidate register.
    seg7_classify u_classify (
        .pattern_i (seg_in),
        .legal_o   (pat_legal),
        .code_o    (pat_code)
    );

    // ------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------
    always_comb begin
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        cnt_d      = cnt_q;
        commit     = 1'b0;
        if (sample_en) begin
            if (!cand_vld_q || (seg_in != cand_q)) begin
                cand_d     = seg_in;
                cand_vld_d = 1'b1;
                cnt_d      = CNT_W'(1);
                commit     = (STABLE_CYCLES == 1);
            end else if (cnt_q < STABLE_CNT) begin
                // Saturating at STABLE_CNT makes a held pattern commit once.
                cnt_d  = cnt_q + CNT_W'(1);
                commit = (cnt_d == STABLE_CNT);
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit, holding register, flags and error counter
    // ------------------------------------------------------------------
    assign consume = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        bad_d       = 1'b0;

        if (commit && pat_legal) begin
            // A consume on the same edge frees the slot for the new code.
            if (!out_valid_q || out_ready) begin
                out_code_d  = pat_code;
                out_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        if (commit && !pat_legal) begin
            bad_d = 1'b1;
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // its _d value from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cand_q      <= '0;
            cand_vld_q  <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= CODE_D;
            bad_q       <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= '0;
        end else begin
            cand_q      <= cand_d;
            cand_vld_q  <= cand_vld_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign bad_pulse = bad_q;
    assign overflow  = ovf_q;
    assign err_count = err_q;

endmodule : seven_segment_reader
